// File: rtl/cdc_handshake_arbiter.sv
// cdc_handshake_arbiter: round-robin sharing of one 4-phase send/rcv CDC channel among N_REQ requesters
module cdc_handshake_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*DATA_W-1:0]    i_data,
    output logic [N_REQ-1:0]           o_ack,
    output logic                       o_src_send,
    output logic [DATA_W-1:0]          o_src_data,
    output logic [$clog2(N_REQ)-1:0]   o_src_id,
    input  logic                       i_src_rcv,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_timeout
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

    state_t            state;
    logic [IW-1:0]     ptr, pick, nxt;
    logic [N_REQ-1:0]  rot;
    logic              any;
    logic [DATA_W-1:0] sel;
    logic [CW-1:0]     cnt;
    logic              timed_out;

    // rotate so bit 0 is the pointer slot; scanning downward leaves the nearest request in pick
    always_comb begin
        rot  = N_REQ'({i_req, i_req} >> ptr);
        any  = 1'b0;
        pick = '0;
        sel  = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) begin
                any  = 1'b1;
                pick = IW'((int'(ptr) + k) % N_REQ);
            end
        for (int k = 0; k < N_REQ; k++)
            if (pick == IW'(k)) sel = i_data[k*DATA_W +: DATA_W];
        nxt = (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
    end

    assign o_busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            timed_out  <= 1'b0;
            o_ack      <= '0;
            o_src_send <= 1'b0;
            o_src_data <= '0;
            o_src_id   <= '0;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            o_ack     <= '0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE:
                    if (!i_src_rcv && any) begin
                        o_src_data <= sel;
                        o_src_id   <= pick;
                        o_src_send <= 1'b1;
                        o_ack      <= N_REQ'(1) << pick;
                        ptr        <= nxt;
                        cnt        <= '0;
                        timed_out  <= 1'b0;
                        state      <= SEND;
                    end
                SEND:
                    if (i_src_rcv) begin
                        o_src_send <= 1'b0;
                        state      <= RELEASE;
                    end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
                        o_src_send <= 1'b0;
                        o_timeout  <= 1'b1;
                        timed_out  <= 1'b1;
                        state      <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                RELEASE:
                    if (!i_src_rcv) begin
                        o_done <= !timed_out;
                        state  <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
